pio_poll_master: RTL

//  Avalon-MM read initiator that periodically polls a read-only PIO slave (in_port at offset 0).

---
 rtl/pio_poll_pkg.sv | 16 +
 rtl/pio_poll_timer.sv | 31 +++
 rtl/pio_poll_master.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pio_poll_pkg.sv
// Shared types and limits for the PIO polling initiator.
package pio_poll_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        LAT  = 2'd2,
        UPD  = 2'd3
    } poll_state_t;

    localparam int POLL_DIV_MIN     = 2;
    localparam int READ_LATENCY_MIN = 1;
    localparam int READ_LATENCY_MAX = 4;
    localparam int LAT_CNT_W        = 2;

endpackage

// File: rtl/pio_poll_timer.sv
// Poll interval down-counter: one-cycle tick every POLL_DIV enabled cycles.
module pio_poll_timer #(
    parameter int POLL_DIV = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;
    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(POLL_DIV - 1);

    logic [CNT_W-1:0] count;

    assign tick = enable && (count == '0);

    // Count is frozen while enable is low so the interval resumes where it stopped.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= RELOAD;
        end else if (enable) begin
            if (count == '0) begin
                count <= RELOAD;
            end else begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pio_poll_master.sv
// Avalon-MM read initiator that polls a PIO input register and reports changes.
module pio_poll_master
    import pio_poll_pkg::*;
#(
    parameter int DATA_W       = 3,
    parameter int ADDR_W       = 2,
    parameter int PIO_ADDR     = 0,
    parameter int POLL_DIV     = 1000,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    input  logic              avm_waitrequest,
    input  logic [31:0]       avm_readdata,
    output logic [DATA_W-1:0] value,
    output logic              valid,
    output logic              change,
    output logic [DATA_W-1:0] change_mask,
    output logic              overrun
);

    localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(READ_LATENCY - 1);

    poll_state_t          state;
    poll_state_t          state_nxt;
    logic                 tick;
    logic                 pending;
    logic                 enter_req;
    logic                 accept;
    logic                 capture;
    logic [LAT_CNT_W-1:0] lat_cnt;
    logic [DATA_W-1:0]    sample;
    logic                 unused_readdata;

    function automatic logic [DATA_W-1:0] diff_mask(
        input logic [DATA_W-1:0] new_val,
        input logic [DATA_W-1:0] old_val,
        input logic              armed
    );
        return armed ? (new_val ^ old_val) : '0;
    endfunction

    pio_poll_timer #(
        .POLL_DIV(POLL_DIV)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    assign avm_address     = ADDR_W'(PIO_ADDR);
    assign avm_read        = (state == REQ);
    assign accept          = avm_read && !avm_waitrequest;
    assign capture         = (state == LAT) && (lat_cnt == '0);
    assign enter_req       = (state_nxt == REQ) && (state != REQ);
    assign unused_readdata = ^avm_readdata[31:DATA_W];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pending || tick) state_nxt = REQ;
            REQ:     if (!avm_waitrequest) state_nxt = LAT;
            LAT:     if (lat_cnt == '0) state_nxt = UPD;
            UPD:     state_nxt = (pending || tick) ? REQ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pending     <= 1'b0;
            overrun     <= 1'b0;
            lat_cnt     <= '0;
            value       <= '0;
            valid       <= 1'b0;
            change      <= 1'b0;
            change_mask <= '0;
        end else begin
            state <= state_nxt;

            // A tick that lands on a REQ entry is absorbed by that read.
            if (enter_req) begin
                pending <= 1'b0;
            end else if (tick) begin
                pending <= 1'b1;
            end
            if (tick && pending && !enter_req) begin
                overrun <= 1'b1;
            end

            if (accept) begin
                lat_cnt <= LAT_INIT;
            end else if ((state == LAT) && (lat_cnt != '0)) begin
                lat_cnt <= lat_cnt - LAT_CNT_W'(1);
            end

            change      <= 1'b0;
            change_mask <= '0;
            if (state == UPD) begin
                value       <= sample;
                valid       <= 1'b1;
                change      <= valid && (sample != value);
                change_mask <= diff_mask(sample, value, valid && (sample != value));
            end
        end
    end

    // Capture register holds data only; state decides whether it is consumed.
    always_ff @(posedge clk) begin
        if (capture) begin
            sample <= avm_readdata[DATA_W-1:0];
        end
    end

endmodule
